// File: rtl/can_frame_sequencer.sv
// CAN frame sequencer: tracks field, bit position and bit-stuffing of received frames.
// Optional extended (29-bit) identifier support is enabled with `define CAN_EXT_ID_EN.
module can_frame_sequencer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       SP,
  input  logic       RX,
  input  logic       STF_ERR,
  output logic       F_STF,
  output logic       STUFF_BIT,
  output logic [3:0] FIELD,
  output logic [6:0] BIT_CNT,
  output logic       FRAME_DONE,
  output logic       FRAME_ERR
);

  localparam int unsigned FieldW     = 4;
  localparam int unsigned CntW       = 7;
  localparam int unsigned RunW       = 3;
  localparam int unsigned IdleW      = 4;
  localparam int unsigned DlcW       = 4;
  localparam int unsigned StuffRun   = 5;
  localparam int unsigned IdleRun    = 11;
  localparam int unsigned IdBaseLast = 10;
  localparam int unsigned IdExtLast  = 17;
  localparam int unsigned CtrlLast   = 2;
  localparam int unsigned DlcLast    = 3;
  localparam int unsigned CrcLast    = 14;
  localparam int unsigned EofLast    = 6;
  localparam int unsigned IfsLast    = 2;
  localparam int unsigned MaxBytes   = 8;

  typedef enum logic [FieldW-1:0] {
    F_IDLE    = 4'd0,
    F_SOF     = 4'd1,
    F_ID      = 4'd2,
    F_CTRL    = 4'd3,
    F_DLC     = 4'd4,
    F_DATA    = 4'd5,
    F_CRC     = 4'd6,
    F_CRC_DEL = 4'd7,
    F_ACK     = 4'd8,
    F_ACK_DEL = 4'd9,
    F_EOF     = 4'd10,
    F_IFS     = 4'd11,
    F_ERROR   = 4'd15
  } field_e;

  field_e            field_q, field_d, pos_f;
  logic [CntW-1:0]   cnt_q, cnt_d, pos_c;
  logic              f_stf_q, f_stf_d;
  logic              stuff_q, stuff_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [RunW-1:0]   run_q, run_d;
  logic              run_val_q, run_val_d;
  logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
  logic              idle_ok_q, idle_ok_d;
  logic [DlcW-1:0]   dlc_q, dlc_d;
  logic              rtr_q, rtr_d;
  logic              ext_q, ext_d;
  logic              idb_q, idb_d;
  logic              sof, go_err;
  logic [DlcW-1:0]   data_bytes;
  logic [CntW-1:0]   data_len;
  logic [CntW-1:0]   id_last;

  // Payload length in bits; remote frames carry no data regardless of DLC.
  always_comb begin
    data_bytes = '0;
    if (!rtr_q) data_bytes = (dlc_q > DlcW'(MaxBytes)) ? DlcW'(MaxBytes) : dlc_q;
    data_len = CntW'({data_bytes, 3'b000});
    id_last  = idb_q ? CntW'(IdExtLast) : CntW'(IdBaseLast);
  end

  always_comb begin
    field_d    = field_q;
    cnt_d      = cnt_q;
    f_stf_d    = f_stf_q;
    stuff_d    = stuff_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    run_d      = run_q;
    run_val_d  = run_val_q;
    idle_cnt_d = idle_cnt_q;
    idle_ok_d  = idle_ok_q;
    dlc_d      = dlc_q;
    rtr_d      = rtr_q;
    ext_d      = ext_q;
    idb_d      = idb_q;
    pos_f      = field_q;
    pos_c      = cnt_q;
    sof        = 1'b0;
    go_err     = 1'b0;

    if (SP) begin
      if (!f_stf_q && !STF_ERR) begin
        go_err = 1'b1;
      end else if (!f_stf_q && run_q == RunW'(StuffRun)) begin
        stuff_d   = 1'b1;
        run_d     = RunW'(1);
        run_val_d = RX;
      end else begin
        stuff_d = 1'b0;
        if (!f_stf_q) begin
          if (RX == run_val_q) begin
            run_d = run_q + RunW'(1);
          end else begin
            run_d     = RunW'(1);
            run_val_d = RX;
          end
        end

        if (field_q == F_ERROR) begin
          if (RX) begin
            if (idle_cnt_q == IdleW'(IdleRun - 1)) begin
              pos_f      = F_IDLE;
              pos_c      = '0;
              idle_ok_d  = 1'b1;
              idle_cnt_d = IdleW'(IdleRun);
            end else begin
              idle_cnt_d = idle_cnt_q + IdleW'(1);
            end
          end else begin
            idle_cnt_d = '0;
          end
        end else if (field_q == F_IDLE || (field_q == F_IFS && cnt_q == CntW'(IfsLast))) begin
          // Bus idle: wait for enough recessive bits, then a dominant bit is SOF
          if (RX) begin
            pos_f = F_IDLE;
            pos_c = '0;
            if (idle_cnt_q != IdleW'(IdleRun)) idle_cnt_d = idle_cnt_q + IdleW'(1);
            if (idle_cnt_q >= IdleW'(IdleRun - 1)) idle_ok_d = 1'b1;
          end else if (idle_ok_q) begin
            sof = 1'b1;
          end else begin
            pos_f      = F_IDLE;
            pos_c      = '0;
            idle_cnt_d = '0;
          end
        end else begin
          case (field_q)
            F_SOF: begin
              pos_f = F_ID;
              pos_c = '0;
            end
            F_ID: begin
              if (cnt_q < id_last) begin
                pos_c = cnt_q + CntW'(1);
              end else begin
                pos_f = F_CTRL;
                pos_c = '0;
              end
            end
            F_CTRL: begin
              if (cnt_q == CntW'(1) && ext_q && !idb_q) begin
                pos_f = F_ID;
                pos_c = '0;
                idb_d = 1'b1;
              end else if (cnt_q < CntW'(CtrlLast)) begin
                pos_c = cnt_q + CntW'(1);
              end else begin
                pos_f = F_DLC;
                pos_c = '0;
              end
            end
            F_DLC: begin
              if (cnt_q < CntW'(DlcLast)) begin
                pos_c = cnt_q + CntW'(1);
              end else begin
                pos_f = (data_len == '0) ? F_CRC : F_DATA;
                pos_c = '0;
              end
            end
            F_DATA: begin
              if (cnt_q < data_len - CntW'(1)) begin
                pos_c = cnt_q + CntW'(1);
              end else begin
                pos_f = F_CRC;
                pos_c = '0;
              end
            end
            F_CRC: begin
              if (cnt_q < CntW'(CrcLast)) begin
                pos_c = cnt_q + CntW'(1);
              end else begin
                pos_f = F_CRC_DEL;
                pos_c = '0;
              end
            end
            F_CRC_DEL: begin
              pos_f = F_ACK;
              pos_c = '0;
            end
            F_ACK: begin
              pos_f = F_ACK_DEL;
              pos_c = '0;
            end
            F_ACK_DEL: begin
              pos_f = F_EOF;
              pos_c = '0;
            end
            F_EOF: begin
              if (cnt_q < CntW'(EofLast)) begin
                pos_c = cnt_q + CntW'(1);
              end else begin
                pos_f = F_IFS;
                pos_c = '0;
              end
            end
            F_IFS: pos_c = cnt_q + CntW'(1);
            default: begin
              pos_f = F_IDLE;
              pos_c = '0;
            end
          endcase

          // Interpret the sampled bit according to its position
          case (pos_f)
            F_CTRL: begin
              if (pos_c == '0) rtr_d = RX;
              if (pos_c == CntW'(1) && !idb_q && RX) begin
`ifdef CAN_EXT_ID_EN
                ext_d = 1'b1;
`else
                go_err = 1'b1;
`endif
              end
            end
            F_DLC: dlc_d = {dlc_q[DlcW-2:0], RX};
            F_CRC_DEL: begin
              f_stf_d = 1'b1;
              if (!RX) go_err = 1'b1;
            end
            F_ACK_DEL: if (!RX) go_err = 1'b1;
            F_EOF: begin
              if (!RX) go_err = 1'b1;
              else if (pos_c == CntW'(EofLast)) done_d = 1'b1;
            end
            F_IFS: begin
              if (pos_c == CntW'(IfsLast)) begin
                if (RX) idle_ok_d = 1'b1;
                else    sof = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      field_d = pos_f;
      cnt_d   = pos_c;

      if (sof) begin
        field_d    = F_SOF;
        cnt_d      = '0;
        f_stf_d    = 1'b0;
        run_d      = RunW'(1);
        run_val_d  = 1'b0;
        idle_cnt_d = '0;
        idle_ok_d  = 1'b0;
        dlc_d      = '0;
        rtr_d      = 1'b0;
        ext_d      = 1'b0;
        idb_d      = 1'b0;
      end

      if (go_err) begin
        field_d    = F_ERROR;
        cnt_d      = '0;
        f_stf_d    = 1'b1;
        stuff_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b1;
        idle_cnt_d = '0;
        idle_ok_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      field_q    <= F_IDLE;
      cnt_q      <= '0;
      f_stf_q    <= 1'b1;
      stuff_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      run_q      <= '0;
      run_val_q  <= 1'b1;
      idle_cnt_q <= '0;
      idle_ok_q  <= 1'b0;
      dlc_q      <= '0;
      rtr_q      <= 1'b0;
      ext_q      <= 1'b0;
      idb_q      <= 1'b0;
    end else begin
      field_q    <= field_d;
      cnt_q      <= cnt_d;
      f_stf_q    <= f_stf_d;
      stuff_q    <= stuff_d;
      done_q     <= done_d;
      err_q      <= err_d;
      run_q      <= run_d;
      run_val_q  <= run_val_d;
      idle_cnt_q <= idle_cnt_d;
      idle_ok_q  <= idle_ok_d;
      dlc_q      <= dlc_d;
      rtr_q      <= rtr_d;
      ext_q      <= ext_d;
      idb_q      <= idb_d;
    end
  end

  assign FIELD      = field_q;
  assign BIT_CNT    = cnt_q;
  assign F_STF      = f_stf_q;
  assign STUFF_BIT  = stuff_q;
  assign FRAME_DONE = done_q;
  assign FRAME_ERR  = err_q;

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Directed bench for can_frame_sequencer: builds stuffed CAN bit streams and checks
// field/bit position, stuffing flags and frame pulses at every sample point.
module tb_can_frame_sequencer;

  logic       clock;
  logic       reset_n;
  logic       SP;
  logic       RX;
  logic       STF_ERR;
  logic       F_STF;
  logic       STUFF_BIT;
  logic [3:0] FIELD;
  logic [6:0] BIT_CNT;
  logic       FRAME_DONE;
  logic       FRAME_ERR;

  can_frame_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .SP         (SP),
    .RX         (RX),
    .STF_ERR    (STF_ERR),
    .F_STF      (F_STF),
    .STUFF_BIT  (STUFF_BIT),
    .FIELD      (FIELD),
    .BIT_CNT    (BIT_CNT),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_ERR  (FRAME_ERR)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       rx;
    logic [3:0] f;
    logic [6:0] c;
    logic       st;
    logic       fs;
  } bit_t;

  bit_t stream[$];
  int   run_len;
  logic run_val;
  int   checks;
  int   errors;
  int   data_seen;
  int   idx;

  localparam logic [14:0] CRC_VAL = 15'h1D0F;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample point; outputs are inspected half a cycle after the sampling edge
  task automatic step(input logic rx, input logic stf);
    @(negedge clock);
    chk("hold_done", 32'(FRAME_DONE), 32'd0);
    chk("hold_err", 32'(FRAME_ERR), 32'd0);
    SP = 1'b1;
    RX = rx;
    STF_ERR = stf;
    @(negedge clock);
    SP = 1'b0;
    STF_ERR = 1'b1;
    RX = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1);
  endtask

  task automatic chk_reset();
    chk("rst_field", 32'(FIELD), 32'd0);
    chk("rst_cnt", 32'(BIT_CNT), 32'd0);
    chk("rst_fstf", 32'(F_STF), 32'd1);
    chk("rst_stuff", 32'(STUFF_BIT), 32'd0);
    chk("rst_done", 32'(FRAME_DONE), 32'd0);
    chk("rst_err", 32'(FRAME_ERR), 32'd0);
  endtask

  // Append one bit; inside the stuffed region insert a complement bit after five equal bits
  task automatic push(input logic b, input logic [3:0] f, input int c, input logic region);
    bit_t e;
    e.rx = b;
    e.f  = f;
    e.c  = 7'(c);
    e.st = 1'b0;
    e.fs = ~region;
    stream.push_back(e);
    if (region) begin
      if (run_len == 0 || b != run_val) begin
        run_len = 1;
        run_val = b;
      end else begin
        run_len++;
      end
      if (run_len == 5) begin
        e.rx = ~b;
        e.st = 1'b1;
        stream.push_back(e);
        run_len = 1;
        run_val = ~b;
      end
    end
  endtask

  task automatic push_field(input logic [63:0] value, input int n, input logic [3:0] f);
    for (int i = 0; i < n; i++) push(value[n-1-i], f, i, 1'b1);
  endtask

  task automatic build(input logic [10:0] id, input logic ext, input logic [17:0] idb,
                       input logic rtr, input logic [3:0] dlc, input logic [63:0] data);
    int n;
    stream.delete();
    run_len = 0;
    run_val = 1'b0;
    push(1'b0, 4'd1, 0, 1'b1);
    push_field(64'(id), 11, 4'd2);
    if (ext) begin
      push(1'b1, 4'd3, 0, 1'b1);
      push(1'b1, 4'd3, 1, 1'b1);
      push_field(64'(idb), 18, 4'd2);
    end
    push(rtr, 4'd3, 0, 1'b1);
    push(1'b0, 4'd3, 1, 1'b1);
    push(1'b0, 4'd3, 2, 1'b1);
    push_field(64'(dlc), 4, 4'd4);
    n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < 8 * n; i++) push(data[63-i], 4'd5, i, 1'b1);
    push_field(64'(CRC_VAL), 15, 4'd6);
    push(1'b1, 4'd7, 0, 1'b0);
    push(1'b0, 4'd8, 0, 1'b0);
    push(1'b1, 4'd9, 0, 1'b0);
    for (int i = 0; i < 7; i++) push(1'b1, 4'd10, i, 1'b0);
    for (int i = 0; i < 3; i++) push(1'b1, 4'd11, i, 1'b0);
  endtask

  function automatic int find(input logic [3:0] f, input logic [6:0] c);
    for (int i = 0; i < stream.size(); i++)
      if (!stream[i].st && stream[i].f == f && stream[i].c == c) return i;
    return 0;
  endfunction

  task automatic run_stream(input int count);
    bit_t e;
    for (int i = 0; i < count; i++) begin
      e = stream[i];
      step(e.rx, 1'b1);
      chk($sformatf("field[%0d]", i), 32'(FIELD), 32'(e.f));
      chk($sformatf("cnt[%0d]", i), 32'(BIT_CNT), 32'(e.c));
      chk($sformatf("stuff[%0d]", i), 32'(STUFF_BIT), 32'(e.st));
      chk($sformatf("fstf[%0d]", i), 32'(F_STF), 32'(e.fs));
      chk($sformatf("done[%0d]", i), 32'(FRAME_DONE), 32'(e.f == 4'd10 && e.c == 7'd6));
      chk($sformatf("err[%0d]", i), 32'(FRAME_ERR), 32'd0);
      if (FIELD === 4'd5 && STUFF_BIT === 1'b0) data_seen++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    data_seen = 0;
    SP = 1'b0;
    RX = 1'b1;
    STF_ERR = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset();
    reset_n = 1'b1;

    // Ten recessive bits are not enough: dominant stays idle
    idle(10);
    step(1'b0, 1'b1);
    chk("early_sof", 32'(FIELD), 32'd0);
    idle(11);

    // Base frame, ID 0x123, one data byte
    build(11'h123, 1'b0, 18'h0, 1'b0, 4'd1, 64'hA500_0000_0000_0000);
    data_seen = 0;
    run_stream(stream.size());
    chk("data_bits_dlc1", 32'(data_seen), 32'd8);

    // ID 0x000, DLC 15 -> 8 bytes, started right after IFS; stuff bit after ID bit 3
    build(11'h000, 1'b0, 18'h0, 1'b0, 4'hF, 64'h0123_4567_89AB_CDEF);
    chk("stuff_model_idx5", 32'(stream[5].st), 32'd1);
    data_seen = 0;
    run_stream(stream.size() - 1);
    chk("data_bits_dlc15", 32'(data_seen), 32'd64);

    // Remote frame starting on the 3rd IFS bit of the previous frame
    build(11'h7FF, 1'b0, 18'h0, 1'b1, 4'd4, 64'h0);
    data_seen = 0;
    run_stream(stream.size());
    chk("data_bits_rtr", 32'(data_seen), 32'd0);

    // Stuff error at DATA bit 5, then recovery after 11 recessive bits
    build(11'h123, 1'b0, 18'h0, 1'b0, 4'd1, 64'hA500_0000_0000_0000);
    idx = find(4'd5, 7'd5);
    run_stream(idx);
    step(stream[idx].rx, 1'b0);
    chk("stferr_field", 32'(FIELD), 32'd15);
    chk("stferr_pulse", 32'(FRAME_ERR), 32'd1);
    chk("stferr_fstf", 32'(F_STF), 32'd1);
    idle(10);
    chk("err_hold", 32'(FIELD), 32'd15);
    step(1'b1, 1'b1);
    chk("err_exit", 32'(FIELD), 32'd0);

    // Form error: dominant CRC delimiter
    build(11'h456, 1'b0, 18'h0, 1'b0, 4'd2, 64'h3CC3_0000_0000_0000);
    idx = find(4'd7, 7'd0);
    run_stream(idx);
    step(1'b0, 1'b1);
    chk("form_field", 32'(FIELD), 32'd15);
    chk("form_pulse", 32'(FRAME_ERR), 32'd1);
    idle(11);

    // Reset during CRC aborts the frame silently and clears the idle condition
    build(11'h123, 1'b0, 18'h0, 1'b0, 4'd1, 64'hA500_0000_0000_0000);
    idx = find(4'd6, 7'd0);
    run_stream(idx + 1);
    reset_n = 1'b0;
    #1;
    chk_reset();
    @(negedge clock);
    chk("rst_hold_done", 32'(FRAME_DONE), 32'd0);
    chk("rst_hold_err", 32'(FRAME_ERR), 32'd0);
    reset_n = 1'b1;
    step(1'b0, 1'b1);
    chk("post_rst_sof", 32'(FIELD), 32'd0);
    idle(11);
    step(1'b0, 1'b1);
    chk("sof_field", 32'(FIELD), 32'd1);
    chk("sof_fstf", 32'(F_STF), 32'd0);
    chk("sof_cnt", 32'(BIT_CNT), 32'd0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(11);

    // Extended-format frame
    build(11'h123, 1'b1, 18'h2AAAA, 1'b0, 4'd1, 64'h5A00_0000_0000_0000);
`ifdef CAN_EXT_ID_EN
    data_seen = 0;
    run_stream(stream.size());
    chk("ext_data_bits", 32'(data_seen), 32'd8);
`else
    idx = find(4'd3, 7'd1);
    run_stream(idx);
    step(1'b1, 1'b1);
    chk("ide_field", 32'(FIELD), 32'd15);
    chk("ide_pulse", 32'(FRAME_ERR), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_frame_sequencer.md
CAN_FRAME_SEQUENCER -- requirements
Module: can_frame_sequencer

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port SP, input, 1 bit: sample-point strobe, one clock wide; the block advances only on clocks with SP=1.
REQ-004 The block SHALL have port RX, input, 1 bit: bus bit sampled when SP=1 (0 dominant, 1 recessive).
REQ-005 The block SHALL have port STF_ERR, input, 1 bit: stuff-error flag from the stuff checker, active-low.
REQ-006 The block SHALL have port F_STF, output, 1 bit: 0 inside the stuffed region (SOF through last CRC bit), 1 elsewhere.
REQ-007 The block SHALL have port STUFF_BIT, output, 1 bit: 1 while the last sampled bit is a stuff bit.
REQ-008 The block SHALL have port FIELD, output, 4 bits: current field code, IDLE=0, SOF=1, ID=2, CTRL=3, DLC=4, DATA=5, CRC=6, CRC_DEL=7, ACK=8, ACK_DEL=9, EOF=10, IFS=11, ERROR=15.
REQ-009 The block SHALL have port BIT_CNT, output, 7 bits: index of the last sampled non-stuff bit within FIELD, starting at 0.
REQ-010 The block SHALL have port FRAME_DONE, output, 1 bit: one-clock pulse at the last EOF bit.
REQ-011 The block SHALL have port FRAME_ERR, output, 1 bit: one-clock pulse on entry to ERROR.

Function
REQ-012 All outputs SHALL be registered and SHALL update on the clock edge that samples SP=1; on other clocks they SHALL hold, except FRAME_DONE and FRAME_ERR, which SHALL return to 0.
REQ-013 In IDLE, once 11 consecutive recessive samples have been seen since reset or ERROR, RX=0 SHALL move the block to SOF; FIELD SHALL be 1 and F_STF SHALL be 0 on the same update.
REQ-014 Field lengths SHALL be: ID 11; CTRL 3 (RTR, IDE, r0); DLC 4; DATA 8*N bits, where N=min(DLC,8), or N=0 if RTR=1; CRC 15; CRC_DEL 1; ACK 1; ACK_DEL 1; EOF 7; IFS 3.
REQ-015 A DATA field with N=0 SHALL be skipped: DLC SHALL go directly to CRC.
REQ-016 While F_STF=0, the block SHALL count consecutive equal bits, including SOF and stuff bits; the sample after a run of 5 SHALL be a stuff bit.
REQ-017 On a stuff bit, STUFF_BIT SHALL be 1, BIT_CNT and FIELD SHALL hold, and the run counter SHALL restart at 1 with the stuff bit's value.
REQ-018 A stuff bit that follows the last CRC bit SHALL still be flagged; F_STF SHALL become 1 only after that stuff bit.
REQ-019 A dominant sample in CRC_DEL, ACK_DEL or EOF SHALL be a form error and SHALL send the block to ERROR.
REQ-020 A dominant sample in ACK SHALL be accepted; the block does not check ACK.
REQ-021 STF_ERR=0 on a clock with SP=1 while F_STF=0 SHALL send the block to ERROR.
REQ-022 On entry to ERROR, FIELD SHALL be 15, F_STF SHALL be 1 and FRAME_ERR SHALL pulse.
REQ-023 ERROR SHALL exit to IDLE after 11 consecutive recessive samples.
REQ-024 After the 3rd IFS bit the block SHALL return to IDLE with the idle condition already met, so a following RX=0 starts SOF.
REQ-025 A dominant bit in IFS bit 3 SHALL be treated as SOF of the next frame.

Reset
REQ-026 While reset_n=0, the block SHALL set FIELD=0, BIT_CNT=0, F_STF=1, STUFF_BIT=0, FRAME_DONE=0 and FRAME_ERR=0.
REQ-027 While reset_n=0, the run and idle counters SHALL be cleared and the idle condition SHALL be unmet.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no FRAME_DONE or FRAME_ERR pulse.

Configuration
REQ-029 When macro CAN_EXT_ID_EN is defined, IDE=1 SHALL select the extended format: after the IDE bit the block SHALL sample ID-B (18 bits, FIELD=2), then RTR, r1 and r0 (FIELD=3), then DLC.
REQ-030 When CAN_EXT_ID_EN is not defined, a recessive IDE bit SHALL send the block to ERROR.

Verification
REQ-031 Base frame ID 0x123, DLC 1, data 0xA5 -> FIELD walks 1,2,3,4,5,6,...,11; exactly 8 DATA bits; one FRAME_DONE pulse; FRAME_ERR stays 0.
REQ-032 ID 0x000 -> a stuff bit after SOF plus 4 ID bits; STUFF_BIT=1 on that update with BIT_CNT held at 3.
REQ-033 DLC 0xF with RTR=0 -> exactly 64 DATA bits, then CRC.
REQ-034 STF_ERR=0 at DATA bit 5 -> FRAME_ERR pulse, FIELD=15; 11 recessive samples -> FIELD=0.
REQ-035 reset_n pulsed low during CRC -> all outputs at reset values; a new SOF is ignored until 11 recessive samples.
REQ-036 A frame with IDE=1 -> with CAN_EXT_ID_EN, 18 ID-B bits and FRAME_DONE; without it, FRAME_ERR at the IDE bit.
